prog_loader: RTL and testbench

Program loader and run controller for the rv32i core. It accepts a stream of instruction words over a valid/ready handshake and writes them into instruction memory. Optionally, it zero-fills the rest of memory. It then releases the core from reset and supervises execution until the core halts or a cycle budget runs out. It replaces ad-hoc memory preloading and fixed-delay run limits with a reusable, synthesizable block that sits between the host/boot source, `insn_memory`'s write port and the core's reset input.

---
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader and run controller: streams a program into instruction memory,
// optionally zero-fills the rest, then runs the core until halt or cycle budget.
module prog_loader #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter bit CLEAR_EN   = 1'b1,
  parameter int MAX_CYCLES = 1000,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              core_reset_n,
  input  logic              halt_in,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  BUDGET    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam bit                BUDGET_EN = (MAX_CYCLES != 32'sd0);

  state_t             state_r;
  logic [ADDR_W-1:0]  ptr_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [XLEN-1:0]    mem_wdata_r;
  logic               core_reset_n_r;
  logic               running_r;
  logic               done_r;
  logic               timeout_r;
  logic               overflow_r;
  logic [ADDR_W:0]    words_loaded_r;
  logic [CNT_W-1:0]   cycles_r;

  logic               handshake_s;
  logic               budget_hit_s;
  logic [CNT_W-1:0]   cycles_next_s;

  // Handshake decode, saturating cycle increment and budget detection
  always_comb begin
    handshake_s   = load_valid & load_ready;
    cycles_next_s = cycles_r;
    budget_hit_s  = 1'b0;
    if (cycles_r == CNT_MAX) begin
      cycles_next_s = cycles_r;
    end else begin
      cycles_next_s = cycles_r + CNT_W'(1);
    end
    // The edge that makes cycles equal the budget is the last edge the core sees
    if (BUDGET_EN) begin
      budget_hit_s = core_reset_n_r && (cycles_next_s == BUDGET);
    end else begin
      budget_hit_s = 1'b0;
    end
  end

  // Controller state machine with registered memory-write and run outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      core_reset_n_r <= 1'b0;
      running_r      <= 1'b0;
      done_r         <= 1'b0;
      timeout_r      <= 1'b0;
      overflow_r     <= 1'b0;
      words_loaded_r <= '0;
      cycles_r       <= '0;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r        <= LOAD;
            ptr_r          <= '0;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
            overflow_r     <= 1'b0;
            words_loaded_r <= '0;
            cycles_r       <= '0;
          end
        end
        LOAD: begin
          if (handshake_s) begin
            mem_we_r       <= 1'b1;
            mem_addr_r     <= ptr_r;
            mem_wdata_r    <= load_data;
            ptr_r          <= ptr_r + ADDR_W'(1);
            words_loaded_r <= words_loaded_r + (ADDR_W+1)'(1);
            if (load_last) begin
              if (CLEAR_EN && (ptr_r != LAST_ADDR)) begin
                state_r <= CLEAR;
              end else begin
                state_r <= RUN;
              end
            end else if (ptr_r == LAST_ADDR) begin
              // Memory full with more program pending: never release the core
              state_r    <= DONE;
              overflow_r <= 1'b1;
              done_r     <= 1'b1;
            end
          end
        end
        CLEAR: begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= ptr_r;
          mem_wdata_r <= '0;
          ptr_r       <= ptr_r + ADDR_W'(1);
          if (ptr_r == LAST_ADDR) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (core_reset_n_r) begin
            cycles_r <= cycles_next_s;
          end
          // Halt takes priority over the budget so timeout stays clear
          if (halt_in) begin
            state_r        <= DONE;
            done_r         <= 1'b1;
            core_reset_n_r <= 1'b0;
            running_r      <= 1'b0;
          end else if (budget_hit_s) begin
            state_r        <= DONE;
            done_r         <= 1'b1;
            timeout_r      <= 1'b1;
            core_reset_n_r <= 1'b0;
            running_r      <= 1'b0;
          end else begin
            core_reset_n_r <= 1'b1;
            running_r      <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          core_reset_n_r <= 1'b0;
          running_r      <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready   = (state_r == LOAD);
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign core_reset_n = core_reset_n_r;
  assign running      = running_r;
  assign done         = done_r;
  assign timeout      = timeout_r;
  assign overflow     = overflow_r;
  assign words_loaded = words_loaded_r;
  assign cycles       = cycles_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized programs checked against a
// reference model of expected writes, run length and completion flags.
module tb_prog_loader;

  localparam int XLEN       = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam bit CLEAR_EN   = 1'b1;
  localparam int MAX_CYCLES = 8;
  localparam int CNT_W      = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [XLEN-1:0]   load_data = '0;
  logic              load_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              core_reset_n;
  logic              halt_in = 1'b0;
  logic              running;
  logic              done;
  logic              timeout;
  logic              overflow;
  logic [ADDR_W:0]   words_loaded;
  logic [CNT_W-1:0]  cycles;

  prog_loader #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_EN(CLEAR_EN),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset_n(core_reset_n), .halt_in(halt_in),
    .running(running), .done(done), .timeout(timeout), .overflow(overflow),
    .words_loaded(words_loaded), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, appended only; scenarios work from snapshots
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [XLEN-1:0]   wr_data_q[$];
  int                wr_cyc_q[$];
  int                hs_cyc_q[$];
  int                rn_high = 0;
  int                run_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (load_valid && load_ready) hs_cyc_q.push_back(cyc);
    if (core_reset_n) rn_high = rn_high + 1;
    if (running) run_cnt = run_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [XLEN-1:0] stim_q[$];

  task automatic check_all_zero(input string name);
    check_eq({name, "_zero_a"}, {load_ready, mem_we, mem_addr, mem_wdata, core_reset_n, running}, 64'd0);
    check_eq({name, "_zero_b"}, {done, timeout, overflow, words_loaded, cycles}, 64'd0);
  endtask

  // Load stim_q, run to completion and compare against the expected outcome
  task automatic run_case(input string name, input bit last_en, input bit gaps, input int halt_at);
    int  n, wb, hb, rb, sb, bound, exp_n, exp_cyc, nw;
    bit  acc, exp_ovf, exp_to, halted;
    n  = stim_q.size();
    wb = wr_addr_q.size();
    hb = hs_cyc_q.size();
    rb = rn_high;
    sb = run_cnt;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({name, "_entry_clear"}, {done, timeout, overflow, words_loaded, cycles}, 64'd0);

    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        load_valid = 1'b0;
        @(posedge clk); #1;
      end
      load_valid = 1'b1;
      load_data  = stim_q[i];
      load_last  = last_en && (i == n - 1);
      acc = 1'b0;
      bound = 0;
      while (!acc && bound < 20) begin
        @(negedge clk);
        acc = load_ready;
        @(posedge clk); #1;
        bound++;
      end
      if (!acc) check_eq({name, "_hs_wait"}, 64'd0, 64'd1);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;

    bound = 0;
    while (bound < 300) begin
      @(negedge clk);
      if (done) break;
      halt_in = (halt_at > 0) && core_reset_n && (cycles == CNT_W'(halt_at - 1));
      bound++;
    end
    halt_in = 1'b0;
    if (!done) check_eq({name, "_done_wait"}, 64'd0, 64'd1);
    repeat (3) @(negedge clk);

    // Reference model
    exp_ovf = !last_en && (n == DEPTH);
    exp_n   = (last_en && CLEAR_EN && n < DEPTH) ? DEPTH : n;
    halted  = (halt_at > 0) && (halt_at <= MAX_CYCLES);
    exp_cyc = exp_ovf ? 0 : (halted ? halt_at : MAX_CYCLES);
    exp_to  = !exp_ovf && !halted;

    nw = wr_addr_q.size() - wb;
    check_eq({name, "_nwrites"}, nw, exp_n);
    check_eq({name, "_nhs"}, hs_cyc_q.size() - hb, n);
    for (int i = 0; i < nw && i < exp_n; i++) begin
      check_eq({name, "_waddr"}, wr_addr_q[wb + i], i);
      check_eq({name, "_wdata"}, wr_data_q[wb + i], (i < n) ? stim_q[i] : 32'd0);
      if (i < n && (hs_cyc_q.size() - hb) == n)
        check_eq({name, "_wlat"}, wr_cyc_q[wb + i], hs_cyc_q[hb + i] + 1);
    end
    if (exp_n > n && nw == exp_n && (hs_cyc_q.size() - hb) == n) begin
      check_eq({name, "_clr_first"}, wr_cyc_q[wb + n], hs_cyc_q[hb + n - 1] + 2);
      check_eq({name, "_clr_span"}, wr_cyc_q[wb + exp_n - 1], wr_cyc_q[wb + n] + (exp_n - n - 1));
    end
    check_eq({name, "_flags"}, {done, timeout, overflow}, {1'b1, exp_to, exp_ovf});
    check_eq({name, "_cycles"}, cycles, exp_cyc);
    check_eq({name, "_words"}, words_loaded, n);
    check_eq({name, "_released_edges"}, rn_high - rb, exp_cyc);
    check_eq({name, "_ran"}, (run_cnt - sb) > 0, !exp_ovf);
    check_eq({name, "_parked"}, {core_reset_n, running}, 64'd0);
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back($urandom);
  endtask

  initial begin
    int n, ha;
    bit g;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    stim_q.delete();
    stim_q.push_back(32'h02A08093);
    stim_q.push_back(32'h01510113);
    stim_q.push_back(32'h4020F1B3);
    run_case("normal", 1'b1, 1'b0, 5);

    fill_random(4);
    run_case("gaps", 1'b1, 1'b1, 3);

    fill_random(5);
    run_case("timeout", 1'b1, 1'b0, 0);

    fill_random(DEPTH);
    run_case("overflow", 1'b0, 1'b0, 0);

    fill_random(2);
    run_case("halt_budget", 1'b1, 1'b0, MAX_CYCLES);

    fill_random(DEPTH);
    run_case("full_noclear", 1'b1, 1'b1, 2);

    // Reset in the middle of the clear phase
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      load_last  = (i == 2);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_clear", mem_we, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("rst_mid");
    fill_random(3);
    run_case("reload", 1'b1, 1'b0, 4);

    for (int k = 0; k < 3; k++) begin
      n  = $urandom_range(15, 1);
      g  = $urandom_range(1, 0) == 1;
      ha = $urandom_range(10, 0);
      fill_random(n);
      run_case("random", 1'b1, g, ha);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
